// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory handshake and the controller-side signals
// (current instruction out, branch decisions and redirect in).
//   master : the fetch unit (drives imemReq/imemAddr and the instruction view)
//   slave  : memory + controller (drives ready/valid/rdata and the decisions)
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  // instruction memory side
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemReady;
  logic            imemValid;
  logic [XLEN-1:0] imemRdata;
  // controller / datapath side
  logic            instrValid;
  logic [XLEN-1:0] instr;
  logic [6:0]      opCode;
  logic [XLEN-1:0] pcOut;
  logic [XLEN-1:0] pcPlus4;
  logic            instrAccept;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic            brCond;
  logic [XLEN-1:0] targetAddr;
  logic [XLEN-1:0] jalrAddr;
  logic            flush;
  logic [XLEN-1:0] flushPc;
  logic            misaligned;

  modport master (
    output imemReq, imemAddr, instrValid, instr, opCode, pcOut, pcPlus4, misaligned,
    input  imemReady, imemValid, imemRdata, instrAccept, branch, jal, jalr, brCond,
           targetAddr, jalrAddr, flush, flushPc
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, opCode, pcOut, pcPlus4, misaligned,
    output imemReady, imemValid, imemRdata, instrAccept, branch, jal, jalr, brCond,
           targetAddr, jalrAddr, flush, flushPc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a one-outstanding-request
// handshake with instruction memory, holds the fetched instruction until the
// core retires it, then picks the next PC from the jalr/jal/branch decisions.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_unit_if.master (memory handshake, instruction view,
//           branch decisions, flush redirect, misaligned pulse)
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] pc_out_r;
  logic            valid_r;
  logic            misaligned_r;
  logic            drop_pending_r;

  logic [XLEN-1:0] raw_target_s;
  logic            taken_s;
  logic [XLEN-1:0] next_pc_s;
  logic            next_mis_s;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Next-PC selection for a retiring instruction: jalr > jal > taken branch > pc+4.
  always_comb begin
    raw_target_s = bus.targetAddr;
    taken_s      = 1'b0;
    if (bus.jalr) begin
      raw_target_s = bus.jalrAddr & ~{{(XLEN-1){1'b0}}, 1'b1};
      taken_s      = 1'b1;
    end else if (bus.jal) begin
      taken_s = 1'b1;
    end else if (bus.branch && bus.brCond) begin
      taken_s = 1'b1;
    end else begin
      taken_s = 1'b0;
    end
    if (taken_s) begin
      next_pc_s  = align_word(raw_target_s);
      // bit1 set means the target was not word aligned; bit0 is legal for jalr only
      next_mis_s = raw_target_s[1];
    end else begin
      next_pc_s  = pc_out_r + XLEN'(4);
      next_mis_s = 1'b0;
    end
  end

  // Fetch FSM with all registered state and outputs; flush overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= REQ;
      pc_r           <= RESET_PC;
      instr_r        <= NOP_INSTR;
      pc_out_r       <= RESET_PC;
      valid_r        <= 1'b0;
      misaligned_r   <= 1'b0;
      drop_pending_r <= 1'b0;
    end else begin
      misaligned_r <= 1'b0;
      if (bus.flush) begin
        pc_r    <= align_word(bus.flushPc);
        valid_r <= 1'b0;
        instr_r <= NOP_INSTR;
        case (state_r)
          REQ: begin
            // a request consumed this edge is in flight and must be discarded
            if (bus.imemReady) begin
              drop_pending_r <= 1'b1;
              state_r        <= WAIT;
            end else begin
              state_r <= REQ;
            end
          end
          WAIT: begin
            if (bus.imemValid) begin
              drop_pending_r <= 1'b0;
              state_r        <= REQ;
            end else begin
              drop_pending_r <= 1'b1;
              state_r        <= WAIT;
            end
          end
          HOLD:    state_r <= REQ;
          default: state_r <= REQ;
        endcase
      end else begin
        case (state_r)
          REQ: begin
            if (bus.imemReady) begin
              state_r <= WAIT;
            end else begin
              state_r <= REQ;
            end
          end
          WAIT: begin
            if (bus.imemValid && drop_pending_r) begin
              drop_pending_r <= 1'b0;
              state_r        <= REQ;
            end else if (bus.imemValid) begin
              instr_r  <= bus.imemRdata;
              pc_out_r <= pc_r;
              valid_r  <= 1'b1;
              state_r  <= HOLD;
            end else begin
              state_r <= WAIT;
            end
          end
          HOLD: begin
            if (bus.instrAccept) begin
              pc_r         <= next_pc_s;
              misaligned_r <= next_mis_s;
              valid_r      <= 1'b0;
              instr_r      <= NOP_INSTR;
              state_r      <= REQ;
            end else begin
              state_r <= HOLD;
            end
          end
          default: state_r <= REQ;
        endcase
      end
    end
  end

  // Request is decoded from the state register and forced low while reset is held.
  assign bus.imemReq    = (state_r == REQ) && !reset;
  assign bus.imemAddr   = pc_r;
  assign bus.instrValid = valid_r;
  assign bus.instr      = instr_r;
  assign bus.opCode     = instr_r[6:0];
  assign bus.pcOut      = pc_out_r;
  assign bus.pcPlus4    = pc_out_r + XLEN'(4);
  assign bus.misaligned = misaligned_r;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the single-cycle RISC-V core.
- Owns the PC and runs a one-outstanding-request handshake with instruction memory.
- Presents the fetched instruction and its opCode field to the main controller and datapath.
- Takes the controller's branch/jal/jalr decisions back to select the next PC. It is the producer end of the opCode/branch-control interface.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word shown while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imemReq  output  1  request valid to instruction memory.
- imemAddr  output  XLEN  word-aligned fetch address, bits[1:0] always 00.
- imemReady  input  1  memory accepts the request this cycle.
- imemValid  input  1  read data valid this cycle.
- imemRdata  input  XLEN  returned instruction word.
- instrValid  output  1  instr/pcOut hold a live instruction.
- instr  output  XLEN  current instruction (NOP_INSTR when instrValid=0).
- opCode  output  7  instr[6:0], feeds main controller.
- pcOut  output  XLEN  PC of current instruction.
- pcPlus4  output  XLEN  pcOut+4, for jal/jalr link.
- instrAccept  input  1  downstream retires current instruction this cycle.
- branch, jal, jalr  input  1 each  controller decodes for current instruction.
- brCond  input  1  branch condition true (from ALU compare).
- targetAddr  input  XLEN  pcOut+imm, for branch/jal.
- jalrAddr  input  XLEN  rs1+imm, for jalr.
- flush  input  1  asynchronous-to-pipeline redirect (trap/debug).
- flushPc  input  XLEN  redirect address for flush.
- misaligned  output  1  one-cycle pulse when a taken target had bit1 set.

Behaviour:
- Reset (async, immediate):
  - state=REQ.
  - pc=RESET_PC; imemReq=0 while reset is asserted.
  - instrValid=0; instr=NOP_INSTR; opCode=7'b0010011; misaligned=0; dropPending=0.
- States:
  - REQ:
    - imemReq=1, imemAddr=pc.
    - imemReady=1 -> WAIT (request consumed that edge).
  - WAIT:
    - imemReq=0.
    - imemValid=1 and dropPending=0 -> latch imemRdata into instr, pcOut=pc, instrValid=1 -> HOLD.
    - imemValid=1 and dropPending=1 -> discard data, clear dropPending -> REQ.
  - HOLD:
    - instrValid=1; instr, pcOut and opCode are stable.
    - instrAccept=1 -> compute next pc, instrValid=0 on the next edge -> REQ.
- Next PC is computed only on HOLD & instrAccept. Priority:
  - jalr: jalrAddr with bit0 cleared.
  - jal: targetAddr.
  - branch&brCond: targetAddr.
  - Otherwise pcOut+4, wrap modulo 2^XLEN.
  - Inputs are ignored outside HOLD&instrAccept.
- Alignment: the selected taken target has bits[1:0] forced to 00. If bit1 of the pre-forced value was 1, misaligned pulses high for exactly that cycle. There is no other side effect.
- Latency: minimum 3 cycles per instruction (REQ with immediate ready, WAIT with next-cycle valid, HOLD with immediate accept). Back-to-back imemValid in the same cycle as the REQ handshake is illegal. Memory returns data no earlier than the cycle after imemReady.
- Flush (highest priority, sampled each rising edge):
  - pc=flushPc with bits[1:0] forced 00, instrValid=0, instr=NOP_INSTR.
  - From REQ or HOLD -> REQ. An instrAccept in the same cycle is ignored.
  - From WAIT, or from REQ with imemReady=1 in the same cycle: set dropPending=1 and go to WAIT. The in-flight response is discarded, then the fetch refetches at flushPc.
  - WAIT with imemValid and flush in the same cycle: data discarded, dropPending stays 0, -> REQ.
- Reset mid-transaction: the outstanding memory response after reset deassertion is not tracked. The memory is reset by the same signal.
- pcPlus4 = pcOut+4 combinationally. opCode = instr[6:0] combinationally.

Test Plan:
- Reset release, memory with ready=1 and valid one cycle later returning 32'h00500093:
  - imemAddr=0 on the first request.
  - instrValid=1 with opCode=7'b0010011, pcOut=0 on cycle 3.
  - Accept -> next imemAddr=4.
- Taken branch at pcOut=0x10, branch=1, brCond=1, targetAddr=0x40, accept -> next imemAddr=0x40. Same case with brCond=0 -> 0x14.
- jalr at pcOut=0x20, jalrAddr=0x103, accept -> imemAddr=0x100 and misaligned=1 for one cycle. With jal=1 also asserted, jalr still wins.
- flush=1 with flushPc=0x200 while in WAIT:
  - The response arriving 2 cycles later (0xDEADBEEF) is dropped, instrValid stays 0.
  - Next request has imemAddr=0x200.
- Stall: hold instrAccept=0 for 5 cycles in HOLD -> instr, pcOut and opCode unchanged, imemReq=0 throughout. Then accept -> sequential pc+4.
- Async reset asserted mid-WAIT -> outputs return to reset values without waiting for a clock edge. Fetch restarts at RESET_PC.
